// File: rtl/h264_intra_nxn_select.sv
// Intra NxN luma predictor and mode selector (V/H/DC by SAD).
// Streams residual and prediction rows under READYO backpressure.
module h264_intra_nxn_select #(
  parameter int BLK       = 4,
  parameter int MODE_BIAS = 0,
  parameter int SADW      = 2*$clog2(BLK)+8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [BLK*8-1:0]   TOPI,
  input  logic [BLK*8-1:0]   LEFTI,
  input  logic               TVALID,
  input  logic               LVALID,
  input  logic [3:0]         PREDMODE,
  input  logic               STROBEI,
  input  logic [BLK*8-1:0]   DATAI,
  output logic               READYI,
  output logic               STROBEO,
  output logic [BLK*9-1:0]   DATAO,
  output logic [BLK*8-1:0]   BASEO,
  input  logic               READYO,
  output logic               MSTROBEO,
  output logic [3:0]         MODEO,
  output logic               PMODEO,
  output logic [2:0]         RMODEO,
  output logic [15:0]        COSTO
);

  localparam int LG = $clog2(BLK);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;

  logic [2:0]         state;
  logic [BLK*8-1:0]   top_q;
  logic [BLK*8-1:0]   left_q;
  logic               tv_q;
  logic               lv_q;
  logic [3:0]         pm_q;
  logic [7:0]         dc_q;
  logic [BLK*8-1:0]   rows [BLK];
  logic [LG-1:0]      rcnt;
  logic [LG-1:0]      kcnt;
  logic [SADW-1:0]    acc_v, acc_h, acc_d;
  logic [SADW-1:0]    ps_v, ps_h, ps_d;
  logic [SADW-1:0]    rs_v, rs_h, rs_d;
  logic               pvld;
  logic               accept;

  logic [12:0]        sum_t, sum_l;
  logic [7:0]         dc_n;
  logic [15:0]        c_v, c_h, c_d, best_c;
  logic [3:0]         mode_n;
  logic               pf_n;
  logic [2:0]         rem_n;
  logic [BLK*8-1:0]   cur, pred;
  logic [BLK*9-1:0]   res;
  logic [7:0]         lft;

  function automatic logic [7:0] absd(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [15:0] cost_of(
    input logic [SADW-1:0] sad,
    input logic [3:0]      m,
    input logic [3:0]      pm
  );
    logic [16:0] c;
    c = 17'(sad) + ((m != pm) ? 17'(MODE_BIAS) : 17'd0);
    return c[16] ? 16'hFFFF : c[15:0];
  endfunction

  assign READYI = !RST && (state == S_IDLE || state == S_LOAD);
  assign accept = STROBEI && READYI && (state == S_LOAD);

  // DC predictor from the neighbours presented with START
  always_comb begin
    sum_t = '0;
    sum_l = '0;
    for (int i = 0; i < BLK; i++) begin
      sum_t = sum_t + 13'(TOPI[i*8 +: 8]);
      sum_l = sum_l + 13'(LEFTI[i*8 +: 8]);
    end
    dc_n = 8'd128;
    unique case (1'b1)
      (TVALID && LVALID):
        dc_n = 8'((sum_t + sum_l + 13'(BLK)) >> (LG + 1));
      (TVALID && !LVALID):
        dc_n = 8'((sum_t + 13'(BLK/2)) >> LG);
      (!TVALID && LVALID):
        dc_n = 8'((sum_l + 13'(BLK/2)) >> LG);
      default:
        dc_n = 8'd128;
    endcase
  end

  // Per-row SAD of the incoming row against each candidate
  always_comb begin
    rs_v = '0;
    rs_h = '0;
    rs_d = '0;
    lft  = left_q[rcnt*8 +: 8];
    for (int x = 0; x < BLK; x++) begin
      rs_v = rs_v + SADW'(absd(DATAI[x*8 +: 8], top_q[x*8 +: 8]));
      rs_h = rs_h + SADW'(absd(DATAI[x*8 +: 8], lft));
      rs_d = rs_d + SADW'(absd(DATAI[x*8 +: 8], dc_q));
    end
  end

  // Biased costs and minimum pick; lower mode wins ties
  always_comb begin
    c_v    = cost_of(acc_v, 4'd0, pm_q);
    c_h    = cost_of(acc_h, 4'd1, pm_q);
    c_d    = cost_of(acc_d, 4'd2, pm_q);
    mode_n = 4'd2;
    best_c = c_d;
    if (lv_q && c_h <= best_c) begin
      mode_n = 4'd1;
      best_c = c_h;
    end
    if (tv_q && c_v <= best_c) begin
      mode_n = 4'd0;
      best_c = c_v;
    end
    pf_n  = (mode_n == pm_q);
    rem_n = 3'd0;
    if (!pf_n)
      rem_n = (mode_n < pm_q) ? mode_n[2:0]
                              : mode_n[2:0] - 3'd1;
  end

  // Prediction row and residual for emitted row kcnt
  always_comb begin
    cur  = rows[kcnt];
    pred = '0;
    unique case (1'b1)
      (MODEO == 4'd0): pred = top_q;
      (MODEO == 4'd1): pred = {BLK{left_q[kcnt*8 +: 8]}};
      default:         pred = {BLK{dc_q}};
    endcase
    for (int x = 0; x < BLK; x++)
      res[x*9 +: 9] = {1'b0, cur[x*8 +: 8]}
                    - {1'b0, pred[x*8 +: 8]};
  end

  assign STROBEO = (state == S_EMIT);
  assign DATAO   = STROBEO ? res  : '0;
  assign BASEO   = STROBEO ? pred : '0;

  // Row buffer write on each accepted input row
  always_ff @(posedge CLK) begin
    if (accept)
      rows[rcnt] <= DATAI;
  end

  // Control FSM, SAD pipeline and mode result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      top_q    <= '0;
      left_q   <= '0;
      tv_q     <= 1'b0;
      lv_q     <= 1'b0;
      pm_q     <= '0;
      dc_q     <= '0;
      rcnt     <= '0;
      kcnt     <= '0;
      acc_v    <= '0;
      acc_h    <= '0;
      acc_d    <= '0;
      ps_v     <= '0;
      ps_h     <= '0;
      ps_d     <= '0;
      pvld     <= 1'b0;
      MSTROBEO <= 1'b0;
      MODEO    <= '0;
      PMODEO   <= 1'b0;
      RMODEO   <= '0;
      COSTO    <= '0;
    end else begin
      MSTROBEO <= 1'b0;
      pvld     <= accept;
      if (accept) begin
        ps_v <= rs_v;
        ps_h <= rs_h;
        ps_d <= rs_d;
      end
      if (pvld) begin
        acc_v <= acc_v + ps_v;
        acc_h <= acc_h + ps_h;
        acc_d <= acc_d + ps_d;
      end
      case (state)
        S_IDLE: begin
          if (START) begin
            top_q  <= TOPI;
            left_q <= LEFTI;
            tv_q   <= TVALID;
            lv_q   <= LVALID;
            pm_q   <= PREDMODE;
            dc_q   <= dc_n;
            acc_v  <= '0;
            acc_h  <= '0;
            acc_d  <= '0;
            rcnt   <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            rcnt <= rcnt + 1'b1;
            if (rcnt == LG'(BLK-1)) begin
              rcnt  <= '0;
              state <= S_DRAIN;
            end
          end
        end
        S_DRAIN:
          state <= S_DECIDE;
        S_DECIDE: begin
          MODEO    <= mode_n;
          COSTO    <= best_c;
          PMODEO   <= pf_n;
          RMODEO   <= rem_n;
          MSTROBEO <= 1'b1;
          kcnt     <= '0;
          state    <= S_EMIT;
        end
        S_EMIT: begin
          if (READYO) begin
            kcnt <= kcnt + 1'b1;
            if (kcnt == LG'(BLK-1)) begin
              kcnt  <= '0;
              state <= S_IDLE;
            end
          end
        end
        default:
          state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_h264_intra_nxn_select.sv
// Randomized bench for h264_intra_nxn_select against a behavioural model.
// Three instances cover BLK=4/bias 0, BLK=4/bias 4 and BLK=8.
module tb_h264_intra_nxn_select;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tvalid;
  logic        lvalid;
  logic        strobei;
  logic        readyo;
  logic [63:0] topi;
  logic [63:0] lefti;
  logic [63:0] datai;
  logic [3:0]  predmode;
  logic [1:0]  sel;

  logic        ry0, ry1, ry2, so0, so1, so2, ms0, ms1, ms2;
  logic        pf0, pf1, pf2;
  logic [3:0]  mo0, mo1, mo2;
  logic [2:0]  rm0, rm1, rm2;
  logic [15:0] co0, co1, co2;
  logic [35:0] d0, d1;
  logic [71:0] d2;
  logic [31:0] b0, b1;
  logic [63:0] b2;

  logic        o_ry, o_so, o_ms, o_pf;
  logic [3:0]  o_mo;
  logic [2:0]  o_rm;
  logic [15:0] o_co;
  logic [71:0] o_do;
  logic [63:0] o_bo;

  logic [7:0]  cur [8][8];
  logic [7:0]  top [8];
  logic [7:0]  left [8];

  int n_tests = 0;
  int n_fail  = 0;

  h264_intra_nxn_select #(.BLK(4), .MODE_BIAS(0)) dut0 (
    .CLK(clk), .RST(rst), .START(start && sel == 2'd0),
    .TOPI(topi[31:0]), .LEFTI(lefti[31:0]),
    .TVALID(tvalid), .LVALID(lvalid), .PREDMODE(predmode),
    .STROBEI(strobei && sel == 2'd0), .DATAI(datai[31:0]),
    .READYI(ry0), .STROBEO(so0), .DATAO(d0), .BASEO(b0),
    .READYO(readyo && sel == 2'd0), .MSTROBEO(ms0),
    .MODEO(mo0), .PMODEO(pf0), .RMODEO(rm0), .COSTO(co0)
  );

  h264_intra_nxn_select #(.BLK(4), .MODE_BIAS(4)) dut1 (
    .CLK(clk), .RST(rst), .START(start && sel == 2'd1),
    .TOPI(topi[31:0]), .LEFTI(lefti[31:0]),
    .TVALID(tvalid), .LVALID(lvalid), .PREDMODE(predmode),
    .STROBEI(strobei && sel == 2'd1), .DATAI(datai[31:0]),
    .READYI(ry1), .STROBEO(so1), .DATAO(d1), .BASEO(b1),
    .READYO(readyo && sel == 2'd1), .MSTROBEO(ms1),
    .MODEO(mo1), .PMODEO(pf1), .RMODEO(rm1), .COSTO(co1)
  );

  h264_intra_nxn_select #(.BLK(8), .MODE_BIAS(0)) dut2 (
    .CLK(clk), .RST(rst), .START(start && sel == 2'd2),
    .TOPI(topi), .LEFTI(lefti),
    .TVALID(tvalid), .LVALID(lvalid), .PREDMODE(predmode),
    .STROBEI(strobei && sel == 2'd2), .DATAI(datai),
    .READYI(ry2), .STROBEO(so2), .DATAO(d2), .BASEO(b2),
    .READYO(readyo && sel == 2'd2), .MSTROBEO(ms2),
    .MODEO(mo2), .PMODEO(pf2), .RMODEO(rm2), .COSTO(co2)
  );

  always #5 clk = ~clk;

  // Route the selected instance to the observed signals
  always_comb begin
    o_ry = ry0; o_so = so0; o_ms = ms0; o_pf = pf0;
    o_mo = mo0; o_rm = rm0; o_co = co0;
    o_do = 72'(d0); o_bo = 64'(b0);
    if (sel == 2'd1) begin
      o_ry = ry1; o_so = so1; o_ms = ms1; o_pf = pf1;
      o_mo = mo1; o_rm = rm1; o_co = co1;
      o_do = 72'(d1); o_bo = 64'(b1);
    end else if (sel == 2'd2) begin
      o_ry = ry2; o_so = so2; o_ms = ms2; o_pf = pf2;
      o_mo = mo2; o_rm = rm2; o_co = co2;
      o_do = d2; o_bo = b2;
    end
  end

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  // kind 0: constants; 1: noisy around a base; 2: uniform random
  task automatic fill(input int kind, input int c,
                      input int t, input int l);
    int base;
    base = $urandom_range(0, 255);
    for (int r = 0; r < 8; r++) begin
      for (int x = 0; x < 8; x++) begin
        unique case (kind)
          0: cur[r][x] = 8'(c);
          1: cur[r][x] = 8'(clamp8(base + $urandom_range(0, 8) - 4));
          default: cur[r][x] = 8'($urandom_range(0, 255));
        endcase
      end
      unique case (kind)
        0: begin top[r] = 8'(t); left[r] = 8'(l); end
        1: begin
          top[r]  = 8'(clamp8(base + $urandom_range(0, 8) - 4));
          left[r] = 8'(clamp8(base + $urandom_range(0, 8) - 4));
        end
        default: begin
          top[r]  = 8'($urandom_range(0, 255));
          left[r] = 8'($urandom_range(0, 255));
        end
      endcase
    end
  endtask

  task automatic run_block(input int s, input bit tv, input bit lv,
                           input int pm, input int bp, input int abort);
    int blk, bias, lg, st, sl, dcv, p, em, ec, ep, er;
    int sad [3];
    int cost [3];
    int k, cyc, low;
    bit first;
    logic [71:0] ed;
    logic [63:0] eb;
    blk  = (s == 2) ? 8 : 4;
    bias = (s == 1) ? 4 : 0;
    lg   = (blk == 8) ? 3 : 2;
    st = 0; sl = 0;
    for (int i = 0; i < blk; i++) begin
      st += int'(top[i]);
      sl += int'(left[i]);
    end
    if (tv && lv)  dcv = (st + sl + blk) >> (lg + 1);
    else if (tv)   dcv = (st + blk / 2) >> lg;
    else if (lv)   dcv = (sl + blk / 2) >> lg;
    else           dcv = 128;
    for (int m = 0; m < 3; m++) begin
      sad[m] = 0;
      for (int r = 0; r < blk; r++)
        for (int x = 0; x < blk; x++) begin
          p = (m == 0) ? int'(top[x]) : (m == 1) ? int'(left[r]) : dcv;
          sad[m] += (int'(cur[r][x]) > p) ? int'(cur[r][x]) - p
                                          : p - int'(cur[r][x]);
        end
      cost[m] = sad[m] + ((m != pm) ? bias : 0);
      if (cost[m] > 65535) cost[m] = 65535;
    end
    em = -1; ec = 0;
    for (int m = 0; m < 3; m++)
      if ((m == 0 && tv) || (m == 1 && lv) || m == 2)
        if (em < 0 || cost[m] < ec) begin
          em = m; ec = cost[m];
        end
    ep = (em == pm) ? 1 : 0;
    er = ep ? 0 : (em < pm) ? em : em - 1;

    sel = 2'(s);
    cyc = 0;
    while (!o_ry && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    chk("ready_idle", 72'(o_ry), 72'd1);
    for (int i = 0; i < 8; i++) begin
      topi[i*8 +: 8]  = top[i];
      lefti[i*8 +: 8] = left[i];
    end
    tvalid = tv; lvalid = lv; predmode = 4'(pm);
    start = 1'b1;
    strobei = 1'($urandom_range(0, 1));
    datai = {$urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0; strobei = 1'b0;
    topi = {$urandom, $urandom}; lefti = {$urandom, $urandom};
    tvalid = 1'($urandom_range(0, 1));
    lvalid = 1'($urandom_range(0, 1));
    predmode = 4'($urandom_range(0, 15));
    for (int r = 0; r < blk; r++) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      chk("ready_load", 72'(o_ry), 72'd1);
      for (int x = 0; x < 8; x++) datai[x*8 +: 8] = cur[r][x];
      strobei = 1'b1;
      @(posedge clk); #1;
      strobei = 1'b0;
      datai = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("ready_drain", 72'(o_ry), 72'd0);
    chk("strobeo_drain", 72'(o_so), 72'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mstrobe_decide", 72'(o_ms), 72'd0);
    @(posedge clk); #1;
    k = 0; cyc = 0; low = 0; first = 1'b1;
    while (k < blk && cyc < 200) begin
      if (k == abort) begin
        rst = 1'b1; readyo = 1'b1;
        @(negedge clk);
        chk("ready_in_rst", 72'(o_ry), 72'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("strobeo_after_rst", 72'(o_so), 72'd0);
        chk("ready_after_rst", 72'(o_ry), 72'd1);
        chk("modeo_after_rst", 72'(o_mo), 72'd0);
        chk("costo_after_rst", 72'(o_co), 72'd0);
        chk("datao_after_rst", o_do, 72'd0);
        @(posedge clk); #1;
        return;
      end
      if (bp == 0) readyo = 1'b1;
      else if (bp == 1) readyo = 1'($urandom_range(0, 1));
      else if (k == 1 && low < 3) begin
        readyo = 1'b0; low++;
      end else readyo = 1'b1;
      @(negedge clk);
      if (first) begin
        chk("mstrobe", 72'(o_ms), 72'd1);
        chk("modeo", 72'(o_mo), 72'(em));
        chk("costo", 72'(o_co), 72'(ec));
        chk("pmodeo", 72'(o_pf), 72'(ep));
        chk("rmodeo", 72'(o_rm), 72'(er));
        first = 1'b0;
      end
      ed = '0; eb = '0;
      for (int x = 0; x < blk; x++) begin
        p = (em == 0) ? int'(top[x]) : (em == 1) ? int'(left[k]) : dcv;
        ed[x*9 +: 9] = 9'(int'(cur[k][x]) - p);
        eb[x*8 +: 8] = 8'(p);
      end
      chk("strobeo", 72'(o_so), 72'd1);
      chk("datao", o_do, ed);
      chk("baseo", 72'(o_bo), 72'(eb));
      if (readyo) k++;
      @(posedge clk); #1;
      cyc++;
    end
    if (k < blk) chk("emit_timeout", 72'(k), 72'(blk));
    readyo = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("strobeo_done", 72'(o_so), 72'd0);
    chk("ready_done", 72'(o_ry), 72'd1);
    chk("mstrobe_done", 72'(o_ms), 72'd0);
    chk("modeo_hold", 72'(o_mo), 72'(em));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; strobei = 1'b0;
    readyo = 1'b1; tvalid = 1'b0; lvalid = 1'b0;
    topi = '0; lefti = '0; datai = '0; predmode = '0; sel = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_ready", 72'(o_ry), 72'd0);
    chk("rst_strobeo", 72'(o_so), 72'd0);
    chk("rst_mstrobe", 72'(o_ms), 72'd0);
    chk("rst_datao", o_do, 72'd0);
    chk("rst_baseo", 72'(o_bo), 72'd0);
    chk("rst_modeo", 72'(o_mo), 72'd0);
    chk("rst_costo", 72'(o_co), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 72'(o_ry), 72'd1);
    @(posedge clk); #1;

    fill(0, 8'h50, 8'h50, 8'h40);
    run_block(0, 1, 1, 0, 0, -1);
    chk("vmatch_mode", 72'(o_mo), 72'd0);
    chk("vmatch_cost", 72'(o_co), 72'd0);
    chk("vmatch_pflag", 72'(o_pf), 72'd1);

    fill(0, 8'h90, 8'h00, 8'h00);
    run_block(0, 0, 0, 0, 0, -1);
    chk("nonbr_mode", 72'(o_mo), 72'd2);
    chk("nonbr_cost", 72'(o_co), 72'd256);
    chk("nonbr_rem", 72'(o_rm), 72'd1);

    fill(0, 8'h30, 8'h30, 8'h30);
    run_block(1, 1, 1, 1, 0, -1);
    chk("bias_mode", 72'(o_mo), 72'd1);
    chk("bias_cost", 72'(o_co), 72'd0);
    run_block(0, 1, 1, 2, 0, -1);
    chk("tie_mode", 72'(o_mo), 72'd0);
    chk("tie_pflag", 72'(o_pf), 72'd0);

    fill(2, 0, 0, 0);
    run_block(0, 1, 1, 1, 2, -1);

    fill(2, 0, 0, 0);
    run_block(0, 1, 1, 0, 0, 2);
    fill(1, 0, 0, 0);
    run_block(0, 1, 1, 2, 1, -1);

    fill(0, 100, 0, 100);
    run_block(2, 0, 1, 2, 0, -1);
    chk("blk8_mode", 72'(o_mo), 72'd1);

    for (int i = 0; i < 30; i++) begin
      fill($urandom_range(1, 2), 0, 0, 0);
      run_block($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 1), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
